forward_hazard_ctrl: RTL and testbench

FORWARD_HAZARD_CTRL -- requirements
Module: forward_hazard_ctrl

---
 rtl/forward_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_forward_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_ctrl.sv
// Forwarding and hazard control for a five-stage pipeline: shadows the EXE/MEM
// producers, picks operand forwarding selects, raises load-use stalls, counts stalls.
module forward_hazard_ctrl #(
    parameter logic FWD_DEFAULT = 1'b1,
    parameter int   CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             fwd_en,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_use_src1,
    input  logic             id_two_src,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic [3:0]       id_dest,
    output logic             stall,
    output logic [1:0]       val_rn_sel,
    output logic [1:0]       val_rm_sel,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXE = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic             r_fwdEn;
    logic             r_exValid;
    logic             r_exWb;
    logic             r_exMr;
    logic [3:0]       r_exDest;
    logic             r_memValid;
    logic             r_memWb;
    logic [3:0]       r_memDest;
    logic [1:0]       r_rnSel;
    logic [1:0]       r_rmSel;
    logic [CNT_W-1:0] r_stallCount;

    logic       w_exMatch1;
    logic       w_exMatch2;
    logic       w_memMatch1;
    logic       w_memMatch2;
    logic       w_hazard;
    logic       w_stall;
    logic       w_loadId;
    logic [1:0] w_rnSelNext;
    logic [1:0] w_rmSelNext;

    // WB-stage producers are never compared: the register file writes early in WB.
    assign w_exMatch1  = r_exValid  & r_exWb  & (r_exDest  == id_src1) & id_use_src1;
    assign w_exMatch2  = r_exValid  & r_exWb  & (r_exDest  == id_src2) & id_two_src;
    assign w_memMatch1 = r_memValid & r_memWb & (r_memDest == id_src1) & id_use_src1;
    assign w_memMatch2 = r_memValid & r_memWb & (r_memDest == id_src2) & id_two_src;

    assign w_hazard = r_fwdEn ? ((w_exMatch1 | w_exMatch2) & r_exMr)
                              : (w_exMatch1 | w_exMatch2 | w_memMatch1 | w_memMatch2);
    assign w_stall  = w_hazard & id_valid & ~flush;
    assign w_loadId = id_valid & ~w_stall & ~flush;

    // Newest producer wins; a bubble entering EXE always gets register-file selects.
    always_comb begin
        w_rnSelNext = SEL_RF;
        w_rmSelNext = SEL_RF;
        if (w_loadId && r_fwdEn) begin
            if (w_exMatch1)       w_rnSelNext = SEL_EXE;
            else if (w_memMatch1) w_rnSelNext = SEL_MEM;
            if (w_exMatch2)       w_rmSelNext = SEL_EXE;
            else if (w_memMatch2) w_rmSelNext = SEL_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwdEn <= FWD_DEFAULT;
        end else begin
            r_fwdEn <= fwd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exValid    <= 1'b0;
            r_exWb       <= 1'b0;
            r_exMr       <= 1'b0;
            r_exDest     <= 4'd0;
            r_memValid   <= 1'b0;
            r_memWb      <= 1'b0;
            r_memDest    <= 4'd0;
            r_rnSel      <= SEL_RF;
            r_rmSel      <= SEL_RF;
            r_stallCount <= '0;
        end else if (!freeze) begin
            r_memValid <= r_exValid;
            r_memWb    <= r_exWb;
            r_memDest  <= r_exDest;
            if (w_loadId) begin
                r_exValid <= 1'b1;
                r_exWb    <= id_wb_en;
                r_exMr    <= id_mem_read;
                r_exDest  <= id_dest;
            end else begin
                r_exValid <= 1'b0;
                r_exWb    <= 1'b0;
                r_exMr    <= 1'b0;
                r_exDest  <= 4'd0;
            end
            r_rnSel <= w_rnSelNext;
            r_rmSel <= w_rmSelNext;
            if (w_stall && (r_stallCount != {CNT_W{1'b1}})) begin
                r_stallCount <= r_stallCount + CNT_W'(1);
            end
        end
    end

    assign stall       = w_stall;
    assign val_rn_sel  = r_rnSel;
    assign val_rm_sel  = r_rmSel;
    assign stall_count = r_stallCount;

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Directed bench for forward_hazard_ctrl; a second 2-bit-counter instance
// shares every input so counter saturation is reachable in a few cycles.
module tb_forward_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        fwdEn = 1'b1;
    logic        idValid = 1'b0;
    logic [3:0]  idSrc1 = 4'd0;
    logic [3:0]  idSrc2 = 4'd0;
    logic        idUseSrc1 = 1'b0;
    logic        idTwoSrc = 1'b0;
    logic        idWbEn = 1'b0;
    logic        idMemRead = 1'b0;
    logic [3:0]  idDest = 4'd0;
    logic        stall;
    logic [1:0]  rnSel;
    logic [1:0]  rmSel;
    logic [15:0] stallCount;
    logic        sStall;
    logic [1:0]  sRnSel;
    logic [1:0]  sRmSel;
    logic [1:0]  sCount;

    int nVectors = 0;
    int nMiscompares = 0;

    forward_hazard_ctrl #(.FWD_DEFAULT(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .fwd_en(fwdEn),
        .id_valid(idValid), .id_src1(idSrc1), .id_src2(idSrc2),
        .id_use_src1(idUseSrc1), .id_two_src(idTwoSrc), .id_wb_en(idWbEn),
        .id_mem_read(idMemRead), .id_dest(idDest), .stall(stall),
        .val_rn_sel(rnSel), .val_rm_sel(rmSel), .stall_count(stallCount)
    );

    forward_hazard_ctrl #(.FWD_DEFAULT(1'b1), .CNT_W(2)) dutSmall (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .fwd_en(fwdEn),
        .id_valid(idValid), .id_src1(idSrc1), .id_src2(idSrc2),
        .id_use_src1(idUseSrc1), .id_two_src(idTwoSrc), .id_wb_en(idWbEn),
        .id_mem_read(idMemRead), .id_dest(idDest), .stall(sStall),
        .val_rn_sel(sRnSel), .val_rm_sel(sRmSel), .stall_count(sCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                         input logic u1, input logic two, input logic wb,
                         input logic mr, input logic [3:0] d);
        idValid = v; idSrc1 = s1; idSrc2 = s2; idUseSrc1 = u1;
        idTwoSrc = two; idWbEn = wb; idMemRead = mr; idDest = d;
    endtask

    task automatic doReset(input logic fwd);
        fwdEn = fwd; freeze = 1'b0; flush = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; fwdEn = 1'b1;
        tick(); tick();
        rst = 1'b0;
        setId(1, 2, 3, 1, 1, 1, 0, 1);
        tick();
        setId(1, 1, 3, 1, 1, 1, 0, 1);
        #1;
        nVectors++;
        if (stall !== 1'b0) begin nMiscompares++; $display("[TB] FAIL pre_rst_stall: got %0b expected 0", stall); end
        tick();
        nVectors++;
        if ({rnSel, rmSel} !== 4'b0100) begin nMiscompares++; $display("[TB] FAIL pre_rst_sel: got %b expected 0100", {rnSel, rmSel}); end
        rst = 1'b1; freeze = 1'b1; flush = 1'b1;
        tick();
        nVectors++;
        if ({rnSel, rmSel} !== 4'b0000) begin nMiscompares++; $display("[TB] FAIL rst_sel: got %b expected 0000", {rnSel, rmSel}); end
        nVectors++;
        if (stallCount !== 16'd0 || sCount !== 2'd0) begin nMiscompares++; $display("[TB] FAIL rst_count: got %0d/%0d expected 0/0", stallCount, sCount); end
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
        setId(1, 1, 1, 1, 1, 1, 0, 5);
        #1;
        nVectors++;
        if (stall !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rst_stall: got %0b expected 0", stall); end
        tick();
        nVectors++;
        if ({rnSel, rmSel} !== 4'b0000) begin nMiscompares++; $display("[TB] FAIL rst_slots_cleared: got %b expected 0000", {rnSel, rmSel}); end
        setId(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_exe_forward();
        doReset(1'b1);
        setId(1, 2, 3, 1, 1, 1, 0, 1);
        tick();
        setId(1, 1, 3, 1, 1, 1, 0, 2);
        #1;
        nVectors++;
        if (stall !== 1'b0) begin nMiscompares++; $display("[TB] FAIL exe_fwd_stall: got %0b expected 0", stall); end
        tick();
        nVectors++;
        if ({rnSel, rmSel} !== 4'b0100) begin nMiscompares++; $display("[TB] FAIL exe_fwd_sel: got %b expected 0100", {rnSel, rmSel}); end
        setId(1, 4, 4, 1, 1, 1, 0, 1);
        tick();
        setId(1, 1, 2, 1, 1, 1, 0, 9);
        tick();
        nVectors++;
        if ({rnSel, rmSel} !== 4'b0110) begin nMiscompares++; $display("[TB] FAIL exe_mem_mix_sel: got %b expected 0110", {rnSel, rmSel}); end
        setId(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_mem_forward();
        doReset(1'b1);
        setId(1, 2, 3, 1, 1, 1, 0, 1);
        tick();
        setId(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        setId(1, 5, 1, 1, 1, 1, 0, 4);
        #1;
        nVectors++;
        if (stall !== 1'b0) begin nMiscompares++; $display("[TB] FAIL mem_fwd_stall: got %0b expected 0", stall); end
        tick();
        nVectors++;
        if ({rnSel, rmSel} !== 4'b0010) begin nMiscompares++; $display("[TB] FAIL mem_fwd_sel: got %b expected 0010", {rnSel, rmSel}); end
        setId(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_load_use();
        doReset(1'b1);
        setId(1, 3, 0, 1, 0, 1, 1, 2);
        tick();
        setId(1, 2, 2, 1, 1, 1, 0, 6);
        #1;
        nVectors++;
        if (stall !== 1'b1) begin nMiscompares++; $display("[TB] FAIL lu_stall_on: got %0b expected 1", stall); end
        tick();
        nVectors++;
        if ({rnSel, rmSel} !== 4'b0000) begin nMiscompares++; $display("[TB] FAIL lu_bubble_sel: got %b expected 0000", {rnSel, rmSel}); end
        nVectors++;
        if (stall !== 1'b0) begin nMiscompares++; $display("[TB] FAIL lu_stall_off: got %0b expected 0", stall); end
        tick();
        nVectors++;
        if ({rnSel, rmSel} !== 4'b1010) begin nMiscompares++; $display("[TB] FAIL lu_sel: got %b expected 1010", {rnSel, rmSel}); end
        nVectors++;
        if (stallCount !== 16'd1) begin nMiscompares++; $display("[TB] FAIL lu_count: got %0d expected 1", stallCount); end
        setId(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_no_forward();
        doReset(1'b0);
        setId(1, 2, 3, 1, 1, 1, 0, 1);
        tick();
        setId(1, 1, 1, 1, 1, 1, 0, 2);
        #1;
        nVectors++;
        if (stall !== 1'b1) begin nMiscompares++; $display("[TB] FAIL nofwd_stall1: got %0b expected 1", stall); end
        tick();
        nVectors++;
        if (stall !== 1'b1) begin nMiscompares++; $display("[TB] FAIL nofwd_stall2: got %0b expected 1", stall); end
        tick();
        nVectors++;
        if (stall !== 1'b0) begin nMiscompares++; $display("[TB] FAIL nofwd_stall3: got %0b expected 0", stall); end
        tick();
        nVectors++;
        if ({rnSel, rmSel} !== 4'b0000) begin nMiscompares++; $display("[TB] FAIL nofwd_sel: got %b expected 0000", {rnSel, rmSel}); end
        nVectors++;
        if (stallCount !== 16'd2) begin nMiscompares++; $display("[TB] FAIL nofwd_count: got %0d expected 2", stallCount); end
        setId(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_freeze();
        doReset(1'b1);
        setId(1, 3, 0, 1, 0, 1, 1, 2);
        tick();
        setId(1, 2, 2, 1, 1, 1, 0, 6);
        freeze = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nVectors++;
            if (stall !== 1'b1 || stallCount !== 16'd0) begin
                nMiscompares++;
                $display("[TB] FAIL freeze_hold[%0d]: got stall=%0b count=%0d expected stall=1 count=0", i, stall, stallCount);
            end
        end
        freeze = 1'b0;
        tick();
        nVectors++;
        if (stallCount !== 16'd1 || stall !== 1'b0) begin nMiscompares++; $display("[TB] FAIL freeze_release: got count=%0d stall=%0b expected count=1 stall=0", stallCount, stall); end
        tick();
        nVectors++;
        if ({rnSel, rmSel} !== 4'b1010) begin nMiscompares++; $display("[TB] FAIL freeze_sel: got %b expected 1010", {rnSel, rmSel}); end
        setId(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_flush();
        doReset(1'b1);
        setId(1, 3, 0, 1, 0, 1, 1, 2);
        tick();
        setId(1, 2, 2, 1, 1, 1, 0, 2);
        flush = 1'b1;
        #1;
        nVectors++;
        if (stall !== 1'b0) begin nMiscompares++; $display("[TB] FAIL flush_stall: got %0b expected 0", stall); end
        flush = 1'b0; idValid = 1'b0;
        #1;
        nVectors++;
        if (stall !== 1'b0) begin nMiscompares++; $display("[TB] FAIL invalid_stall: got %0b expected 0", stall); end
        flush = 1'b1; idValid = 1'b1;
        tick();
        nVectors++;
        if (stallCount !== 16'd0) begin nMiscompares++; $display("[TB] FAIL flush_count: got %0d expected 0", stallCount); end
        flush = 1'b0;
        setId(1, 2, 0, 1, 0, 1, 0, 7);
        tick();
        nVectors++;
        if ({rnSel, rmSel} !== 4'b1000) begin nMiscompares++; $display("[TB] FAIL flush_bubble_sel: got %b expected 1000", {rnSel, rmSel}); end
        setId(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_r15_and_use();
        doReset(1'b1);
        setId(1, 0, 0, 1, 1, 1, 0, 15);
        tick();
        tick();
        setId(1, 15, 15, 0, 1, 1, 0, 3);
        tick();
        nVectors++;
        if ({rnSel, rmSel} !== 4'b0001) begin nMiscompares++; $display("[TB] FAIL r15_sel: got %b expected 0001", {rnSel, rmSel}); end
        setId(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back_saturation();
        doReset(1'b0);
        setId(1, 1, 1, 1, 0, 1, 0, 1);
        tick();
        tick();
        tick();
        nVectors++;
        if (sCount !== 2'd2) begin nMiscompares++; $display("[TB] FAIL sat_pre: got %0d expected 2", sCount); end
        repeat (5) tick();
        nVectors++;
        if (sCount !== 2'd3 || stallCount !== 16'd5) begin nMiscompares++; $display("[TB] FAIL sat_hold: got %0d/%0d expected 3/5", sCount, stallCount); end
        nVectors++;
        if (stall !== 1'b1) begin nMiscompares++; $display("[TB] FAIL sat_midstall: got %0b expected 1", stall); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        nVectors++;
        if (stallCount !== 16'd0 || sCount !== 2'd0 || {rnSel, rmSel} !== 4'b0000 || stall !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL sat_reset: got count=%0d/%0d sel=%b stall=%0b expected 0/0 0000 0", stallCount, sCount, {rnSel, rmSel}, stall);
        end
        setId(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_exe_forward();
        test_mem_forward();
        test_load_use();
        test_no_forward();
        test_freeze();
        test_flush();
        test_r15_and_use();
        test_back_to_back_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
